// File: rtl/psum_acc_if.sv
// Handshake bundle between the MAC-array controller, psum_acc and the quant/writeback stage.
interface psum_acc_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DIN_W = 24,
  parameter int unsigned ACC_W = 26
);
  logic                   in_vld;
  logic                   in_rdy;
  logic [LANES*DIN_W-1:0] in_data;
  logic [13:0]            in_info;
  logic                   out_vld;
  logic                   out_rdy;
  logic [LANES*ACC_W-1:0] out_data;
  logic [12:0]            out_info;
  logic                   tile_done;
  logic                   seq_err;

  modport slave (
    input  in_vld, in_data, in_info, out_rdy,
    output in_rdy, out_vld, out_data, out_info, tile_done, seq_err
  );

  modport master (
    output in_vld, in_data, in_info, out_rdy,
    input  in_rdy, out_vld, out_data, out_info, tile_done, seq_err
  );
endinterface

// File: rtl/psum_acc.sv
// Two-pass partial-sum accumulator: group-0 beats are parked in a pixel buffer, group-1 beats add to them.
// Optional macro PSUM_ACC_RELU_EN clamps negative lane sums to zero before the output register.
module psum_acc #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned DIN_W   = 24,
  parameter int unsigned ACC_W   = 26,
  parameter int unsigned MAP_PIX = 3136
) (
  input logic       clk,
  input logic       rst,
  psum_acc_if.slave bus
);
  localparam int unsigned DW       = LANES * DIN_W;
  localparam int unsigned AW       = LANES * ACC_W;
  localparam logic [11:0] LAST_OFF = 12'(MAP_PIX - 1);

  localparam logic [1:0] WAIT_G0 = 2'd0;
  localparam logic [1:0] IN_G0   = 2'd1;
  localparam logic [1:0] IN_G1   = 2'd2;

  logic          w_adv;
  logic          w_acc;
  logic          w_in_ok;
  logic          w_s1_ok;
  logic          w_exp_grp;
  logic [AW-1:0] w_sum;

  logic signed [ACC_W-1:0] w_a;
  logic signed [ACC_W-1:0] w_b;
  logic signed [ACC_W-1:0] w_lane;

  logic          r_s1_vld;
  logic [DW-1:0] r_s1_data;
  logic [13:0]   r_s1_info;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_mem [MAP_PIX];

  logic          r_out_vld;
  logic [AW-1:0] r_out_data;
  logic [12:0]   r_out_info;

  logic [1:0]    r_state;
  logic [11:0]   r_exp_off;
  logic          r_seq_err;

  assign w_adv   = !r_out_vld || bus.out_rdy;
  assign w_acc   = bus.in_vld && w_adv;
  assign w_in_ok = bus.in_info[11:0] <= LAST_OFF;
  assign w_s1_ok = r_s1_info[11:0] <= LAST_OFF;

  assign bus.in_rdy    = w_adv;
  assign bus.out_vld   = r_out_vld;
  assign bus.out_data  = r_out_data;
  assign bus.out_info  = r_out_info;
  assign bus.seq_err   = r_seq_err;
  assign bus.tile_done = r_out_vld && bus.out_rdy && (r_out_info[11:0] == LAST_OFF);

  // Pixel buffer; out-of-map offsets are dropped so a bad beat cannot index past the array.
  always_ff @(posedge clk) begin
    if (w_adv && r_s1_vld && !r_s1_info[12] && w_s1_ok) begin
      r_mem[r_s1_info[11:0]] <= r_s1_data;
    end
    if (w_acc && bus.in_info[12] && w_in_ok) begin
      r_rd_data <= r_mem[bus.in_info[11:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_info <= '0;
    end else if (w_adv) begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_data <= bus.in_data;
        r_s1_info <= bus.in_info;
      end
    end
  end

  always_comb begin
    w_sum  = '0;
    w_a    = '0;
    w_b    = '0;
    w_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_a    = {{(ACC_W-DIN_W){r_s1_data[i*DIN_W+DIN_W-1]}}, r_s1_data[i*DIN_W +: DIN_W]};
      w_b    = {{(ACC_W-DIN_W){r_rd_data[i*DIN_W+DIN_W-1]}}, r_rd_data[i*DIN_W +: DIN_W]};
      w_lane = w_a + w_b;
`ifdef PSUM_ACC_RELU_EN
      if (w_lane[ACC_W-1]) begin
        w_lane = '0;
      end
`endif
      w_sum[i*ACC_W +: ACC_W] = w_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_info <= '0;
    end else if (w_adv) begin
      if (r_s1_vld && r_s1_info[12]) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_sum;
        r_out_info <= {r_s1_info[13], r_s1_info[11:0]};
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign w_exp_grp = (r_state == IN_G1);

  // Sequence tracker follows the expected counter, not the received beat, so one
  // bad beat flags seq_err without desynchronising the rest of the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_G0;
      r_exp_off <= '0;
      r_seq_err <= 1'b0;
    end else if (w_acc) begin
      if ((bus.in_info[12] != w_exp_grp) || (bus.in_info[11:0] != r_exp_off)) begin
        r_seq_err <= 1'b1;
      end
      r_exp_off <= (r_exp_off == LAST_OFF) ? 12'd0 : r_exp_off + 12'd1;
      case (r_state)
        WAIT_G0: r_state <= IN_G0;
        IN_G0:   if (r_exp_off == LAST_OFF) r_state <= IN_G1;
        IN_G1:   if (r_exp_off == LAST_OFF) r_state <= WAIT_G0;
        default: r_state <= WAIT_G0;
      endcase
    end
  end
endmodule

// File: doc/psum_acc.md
Name: psum_acc

Overview:
- Sits directly downstream of the MAC-array controller.
- Consumes the array's partial-sum stream over a valid/ready handshake, together with the 14-bit info word (out-channel half, input-channel group, 12-bit pixel offset).
- Input-group 0 partial sums are parked in an on-chip psum buffer. Input-group 1 partial sums are added to the parked value, and the finished output-map pixel is emitted to the next stage (quant/writeback) over valid/ready.

Parameters:
- LANES, 8, output channels processed in parallel per beat.
- DIN_W, 24, signed width of one incoming partial-sum lane.
- ACC_W, 26, signed width of one accumulated lane (DIN_W+2; the sum never overflows).
- MAP_PIX, 3136, pixels per output map (56x56); the offset wraps at MAP_PIX-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_vld  in  1  partial-sum beat valid (from mac_array2psum_acc_vld).
- in_rdy  out  1  beat accepted when in_vld&&in_rdy (drives mac_array2psum_acc_rdy).
- in_data  in  LANES*DIN_W  signed partial sums; lane i at [i*DIN_W +: DIN_W].
- in_info  in  14  [13] out-ch half, [12] input group, [11:0] pixel offset.
- out_vld  out  1  accumulated pixel valid.
- out_rdy  in  1  downstream ready.
- out_data  out  LANES*ACC_W  accumulated sums; lane i at [i*ACC_W +: ACC_W].
- out_info  out  13  [12] out-ch half, [11:0] pixel offset.
- tile_done  out  1  one-cycle pulse when the pixel with offset MAP_PIX-1 is handed off (out_vld&&out_rdy).
- seq_err  out  1  sticky: protocol violation seen.

Behaviour:
- Global advance: adv = !out_vld || out_rdy; in_rdy = adv. All pipeline registers, buffer reads and buffer writes are gated by adv.
- Buffer: MAP_PIX x LANES*DIN_W simple-dual-port synchronous RAM, 1-cycle read. Read data holds when the read enable is low. Contents are not reset.
- Stage 0, on acceptance:
  - Register data/info into stage 1 (s1_vld<=1).
  - If info[12]==1, issue a buffer read at info[11:0].
  - If no acceptance while adv=1, s1_vld<=0.
- Stage 1, group 0 beat, while adv: write s1_data to buffer[s1_offset]. Produces no output.
- Stage 1, group 1 beat, while adv: out_data lane i <= sext(s1 lane i) + sext(buffer lane i); out_info <= {half, offset}; out_vld<=1.
- Output register: out_vld clears when handed off and no new sum is loaded.
- Latency: a group-1 beat accepted in cycle T appears on out_vld in T+2 when unstalled.
- Throughput: 1 beat/cycle when out_rdy stays high.
- No RAW hazard: a pass-1 read of offset a always occurs at least MAP_PIX-1 cycles after the pass-0 write of a.
- Sequence FSM (tracks accepted beats), states WAIT_G0, IN_G0, IN_G1:
  - WAIT_G0: accepting a group-0 beat at offset 0 -> IN_G0.
  - IN_G0: accepting offset MAP_PIX-1 -> IN_G1.
  - IN_G1: accepting offset MAP_PIX-1 -> WAIT_G0.
  - Expected offset counter increments per accepted beat and wraps MAP_PIX-1 -> 0.
  - Any accepted beat whose group or offset differs from expected sets seq_err. The FSM/counter still follow the expected sequence and the beat is processed normally.
  - seq_err clears only on rst.
- Out-channel half: passed through unchanged; no checks on it.
- Reset values: out_vld=0, out_data=0, out_info=0, tile_done=0, seq_err=0, s1_vld=0, FSM=WAIT_G0, counter=0.
- in_rdy reflects adv after reset, so it is 1 while out_vld=0.
- rst mid-tile: all in-flight beats are discarded; the next beat must restart at group 0, offset 0.
- Simultaneous hand-off and load: when out_vld&&out_rdy and a new sum arrives in the same cycle, out_vld stays 1 with the new data.

Optional Feature:
- Macro PSUM_ACC_RELU_EN.
- Defined: each lane sum is clamped to 0 when negative, before it enters the output register.
- Undefined: raw signed sum is passed through.
- Latency is unchanged either way.

Test Plan:
- Full tile, out_rdy=1, lane0 group0=offset, group1=2*offset -> 3136 outputs, lane0=3*offset, offsets in order, tile_done once on offset 3135, seq_err=0.
- Signed extremes: group0 lane=-2^23, group1=-2^23 -> out=-2^24 at ACC_W=26 with no wrap. With PSUM_ACC_RELU_EN -> out=0.
- Backpressure: random out_rdy at 50% across a full tile -> no lost or duplicated pixel, out_data stable while out_vld&&!out_rdy, in_rdy==(!out_vld||out_rdy).
- Latency: single group-1 beat at offset 5 in cycle T with out_rdy=1 -> out_vld only in T+2, out_info={half,5}.
- Protocol error: group-1 beat while in WAIT_G0 -> seq_err=1 and held through subsequent correct tiles.
- rst asserted at offset 1000 of group 1 -> all outputs at reset values next cycle. A fresh full tile then produces correct sums and no seq_err.
